capture_trig_seq: RTL and testbench

Capture sequencer for the logic analyzer's sample buffer. It owns the sample RAM write pointer and runs the whole capture: pre-trigger fill, arming, trigger qualification, post-trigger count and completion. Trigger sources are the protocol trigger (`protTrig` from the SPI/UART trigger block) and the channel trigger. Configuration comes from the command/register block; `capture_done` and `trig_addr` are returned to it for readback.

---
 rtl/capture_trig_seq_if.sv | 29 ++
 rtl/capture_trig_seq.sv | 136 +++++++++++++
 tb/tb_capture_trig_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_trig_seq_if.sv
// Control/status bundle between the capture sequencer and its neighbours:
// config and trigger conditions in, sample RAM write port and status out.
interface capture_trig_seq_if #(parameter int ADDR_W = 9);
  logic              capture_start;
  logic              abort;
  logic              smpl_en;
  logic              chTrig;
  logic              protTrig;
  logic [1:0]        trig_src;
  logic [3:0]        trig_occ;
  logic [ADDR_W-1:0] trig_pos;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              armed;
  logic              triggered;
  logic              capture_done;
  logic              busy;

  modport master (
    output capture_start, abort, smpl_en, chTrig, protTrig, trig_src, trig_occ, trig_pos,
    input  we, waddr, trig_addr, armed, triggered, capture_done, busy
  );

  modport slave (
    input  capture_start, abort, smpl_en, chTrig, protTrig, trig_src, trig_occ, trig_pos,
    output we, waddr, trig_addr, armed, triggered, capture_done, busy
  );
endinterface

// File: rtl/capture_trig_seq.sv
// Capture sequencer: owns the sample RAM write pointer and runs pre-trigger fill,
// arming, trigger qualification, post-trigger count and completion.
module capture_trig_seq #(
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  capture_trig_seq_if.slave  bus
);
  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} seqStateT;

  seqStateT          state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trigAddr;
  logic [ADDR_W-1:0] trigPos;
  logic [ADDR_W:0]   preCnt;
  logic [ADDR_W-1:0] postCnt;
  logic [3:0]        edgeCnt;
  logic              prevCond;
  logic              armed;
  logic              triggered;
  logic              captureDone;
  logic              busy;

  logic              cond;
  logic              condEdge;
  logic              postDone;
  logic              writeEn;
  logic              fillDone;
  logic              trigFire;
  logic [ADDR_W:0]   fillTarget;

  always_comb begin
    case (bus.trig_src)
      2'b00:   cond = 1'b1;
      2'b01:   cond = bus.chTrig;
      2'b10:   cond = bus.protTrig;
      default: cond = bus.chTrig & bus.protTrig;
    endcase
  end

  assign condEdge   = cond & ~prevCond;
  // The extra POST cycle after the last post write must not write again.
  assign postDone   = (postCnt == trigPos);
  assign writeEn    = bus.smpl_en &
                      ((state == FILL) || (state == ARMED) || ((state == POST) && !postDone));
  assign fillTarget = DEPTH - {1'b0, trigPos};
  assign fillDone   = writeEn && ((preCnt + CNT_ONE) == fillTarget);
  assign trigFire   = (bus.trig_src == 2'b00) || (condEdge && (edgeCnt == bus.trig_occ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      waddr       <= '0;
      trigAddr    <= '0;
      trigPos     <= '0;
      preCnt      <= '0;
      postCnt     <= '0;
      edgeCnt     <= '0;
      prevCond    <= 1'b0;
      armed       <= 1'b0;
      triggered   <= 1'b0;
      captureDone <= 1'b0;
      busy        <= 1'b0;
    end else begin
      prevCond <= cond;
      if (writeEn) begin
        waddr <= waddr + ADDR_ONE;
      end
      if (bus.abort) begin
        state       <= IDLE;
        armed       <= 1'b0;
        triggered   <= 1'b0;
        captureDone <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.capture_start) begin
              state       <= FILL;
              waddr       <= '0;
              preCnt      <= '0;
              postCnt     <= '0;
              edgeCnt     <= '0;
              trigPos     <= bus.trig_pos;
              triggered   <= 1'b0;
              captureDone <= 1'b0;
              busy        <= 1'b1;
            end
          end
          FILL: begin
            if (writeEn) begin
              preCnt <= preCnt + CNT_ONE;
            end
            if (fillDone) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end
          ARMED: begin
            if (trigFire) begin
              state     <= POST;
              trigAddr  <= waddr;
              triggered <= 1'b1;
              armed     <= 1'b0;
            end else if (condEdge) begin
              edgeCnt <= edgeCnt + 4'd1;
            end
          end
          POST: begin
            if (postDone) begin
              state       <= DONE;
              busy        <= 1'b0;
              captureDone <= 1'b1;
            end else if (writeEn) begin
              postCnt <= postCnt + ADDR_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.we           = writeEn;
  assign bus.waddr        = waddr;
  assign bus.trig_addr    = trigAddr;
  assign bus.armed        = armed;
  assign bus.triggered    = triggered;
  assign bus.capture_done = captureDone;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_capture_trig_seq.sv
// Directed bench for capture_trig_seq (16-entry buffer) with a per-cycle
// reference model of the capture rules and literal checkpoints.
module tb_capture_trig_seq;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_ARMED = 2;
  localparam int P_POST  = 3;
  localparam int P_DONE  = 4;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;
  int   weCount;

  capture_trig_seq_if #(.ADDR_W(AW)) bus ();

  capture_trig_seq #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus write/edge tallies, advanced once per cycle.
  int mPhase, mWaddr, mTrigAddr, mFill, mPost, mPos, mEdges;
  bit mTriggered, mPrev;

  initial begin
    bit expWe, cond, edgeNow;
    int curAddr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mPhase = P_IDLE; mWaddr = 0; mTrigAddr = 0; mFill = 0; mPost = 0;
        mPos = 0; mEdges = 0; mTriggered = 0; mPrev = 0;
      end
      expWe = bus.smpl_en && ((mPhase == P_FILL) || (mPhase == P_ARMED) ||
                              ((mPhase == P_POST) && (mPost < mPos)));
      if (bus.we) weCount++;
      check("we",           bus.we,           expWe);
      check("waddr",        bus.waddr,        mWaddr);
      check("trig_addr",    bus.trig_addr,    mTrigAddr);
      check("armed",        bus.armed,        mPhase == P_ARMED);
      check("triggered",    bus.triggered,    mTriggered);
      check("capture_done", bus.capture_done, mPhase == P_DONE);
      check("busy",         bus.busy,         (mPhase >= P_FILL) && (mPhase <= P_POST));
      if (rst_n) begin
        case (bus.trig_src)
          2'b00:   cond = 1'b1;
          2'b01:   cond = bus.chTrig;
          2'b10:   cond = bus.protTrig;
          default: cond = bus.chTrig && bus.protTrig;
        endcase
        edgeNow = cond && !mPrev;
        mPrev   = cond;
        curAddr = mWaddr;
        if (expWe) mWaddr = (mWaddr + 1) % DEPTH;
        if (bus.abort) begin
          mPhase = P_IDLE;
          mTriggered = 0;
        end else if ((mPhase == P_IDLE || mPhase == P_DONE) && bus.capture_start) begin
          mPhase = P_FILL; mWaddr = 0; mFill = 0; mPost = 0; mEdges = 0;
          mTriggered = 0; mPos = int'(bus.trig_pos);
        end else if (mPhase == P_FILL) begin
          if (expWe) mFill++;
          if (mFill == DEPTH - mPos) mPhase = P_ARMED;
        end else if (mPhase == P_ARMED) begin
          if (bus.trig_src == 2'b00 || (edgeNow && mEdges == int'(bus.trig_occ))) begin
            mTrigAddr = curAddr; mTriggered = 1; mPhase = P_POST;
          end else if (edgeNow) begin
            mEdges++;
          end
        end else if (mPhase == P_POST) begin
          if (mPost >= mPos) mPhase = P_DONE;
          else if (expWe) mPost++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    bus.capture_start = 1'b1;
    tick();
    bus.capture_start = 1'b0;
  endtask

  task automatic waitArmed();
    int n;
    n = 0;
    while (!bus.armed && n < 40) begin
      tick();
      n++;
    end
    if (!bus.armed) check("armed_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!bus.capture_done && n < 40) begin
      tick();
      n++;
    end
    if (!bus.capture_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nCompared = 0; nMismatched = 0; weCount = 0;
    rst_n = 1'b0;
    bus.capture_start = 1'b0; bus.abort = 1'b0; bus.smpl_en = 1'b1;
    bus.chTrig = 1'b0; bus.protTrig = 1'b0;
    bus.trig_src = 2'b10; bus.trig_occ = 4'd0; bus.trig_pos = 4'd4;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("reset_busy", bus.busy, 1'b0);

    // 1: protocol trigger, 4 post samples, pointer wraps
    weCount = 0;
    pulseStart();
    waitArmed();
    check("t1_arm_waddr", bus.waddr, 4'd12);
    repeat (3) tick();
    bus.protTrig = 1'b1;
    tick();
    bus.protTrig = 1'b0;
    check("t1_triggered", bus.triggered, 1'b1);
    waitDone();
    check("t1_trig_addr", bus.trig_addr, 4'd15);
    check("t1_final_waddr", bus.waddr, 4'd4);
    check("t1_writes", weCount, 20);
    $display("capture 1: trig_addr=%0d waddr=%0d writes=%0d", bus.trig_addr, bus.waddr, weCount);

    // 2: third chTrig edge, level held through FILL not counted
    bus.trig_src = 2'b01; bus.trig_occ = 4'd2; bus.chTrig = 1'b1;
    pulseStart();
    waitArmed();
    repeat (2) tick();
    bus.chTrig = 1'b0;
    tick();
    for (int p = 0; p < 3; p++) begin
      bus.chTrig = 1'b1;
      tick();
      bus.chTrig = 1'b0;
      check("t2_triggered_after_pulse", bus.triggered, (p == 2));
      repeat (2) tick();
    end
    waitDone();
    $display("capture 2: trig_addr=%0d waddr=%0d", bus.trig_addr, bus.waddr);

    // 3: forced trigger, trig_pos=0, restart from DONE
    bus.trig_src = 2'b00; bus.trig_pos = 4'd0;
    pulseStart();
    check("t3_done_dropped", bus.capture_done, 1'b0);
    check("t3_waddr_restart", bus.waddr, 4'd0);
    waitArmed();
    tick();
    check("t3_post_we", bus.we, 1'b0);
    check("t3_post_busy", bus.busy, 1'b1);
    tick();
    check("t3_done", bus.capture_done, 1'b1);
    check("t3_trig_addr", bus.trig_addr, 4'd0);
    check("t3_final_waddr", bus.waddr, 4'd1);
    repeat (3) tick();
    check("t3_done_we", bus.we, 1'b0);
    $display("capture 3: trig_addr=%0d waddr=%0d", bus.trig_addr, bus.waddr);

    // 4: abort coincident with a protocol trigger edge
    bus.trig_src = 2'b10; bus.trig_pos = 4'd4;
    pulseStart();
    waitArmed();
    bus.abort = 1'b1; bus.protTrig = 1'b1;
    tick();
    bus.abort = 1'b0; bus.protTrig = 1'b0;
    check("t4_triggered", bus.triggered, 1'b0);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_waddr", bus.waddr, 4'd13);
    weCount = 0;
    repeat (3) tick();
    check("t4_no_writes", weCount, 0);
    $display("capture 4: aborted, waddr=%0d", bus.waddr);

    // 5: start ignored in POST, trig_pos change mid-capture ignored
    bus.trig_src = 2'b00;
    pulseStart();
    bus.trig_pos = 4'd0;
    waitArmed();
    check("t5_arm_waddr", bus.waddr, 4'd12);
    tick();
    pulseStart();
    check("t5_busy_in_post", bus.busy, 1'b1);
    waitDone();
    check("t5_trig_addr", bus.trig_addr, 4'd12);
    check("t5_final_waddr", bus.waddr, 4'd1);
    $display("capture 5: trig_addr=%0d waddr=%0d", bus.trig_addr, bus.waddr);

    // 6: asynchronous reset in the middle of POST
    bus.trig_pos = 4'd4;
    pulseStart();
    check("t6_restart_waddr", bus.waddr, 4'd0);
    waitArmed();
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_we", bus.we, 1'b0);
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_triggered", bus.triggered, 1'b0);
    check("t6_rst_waddr", bus.waddr, 4'd0);
    check("t6_rst_trig_addr", bus.trig_addr, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();
    check("t6_idle_busy", bus.busy, 1'b0);
    check("t6_idle_done", bus.capture_done, 1'b0);
    $display("capture 6: reset mid-POST, waddr=%0d", bus.waddr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
